// File: rtl/mem_arbiter.sv
// Burst memory arbiter: round-robin sharing of one backing-memory port between
// icache line reads and dcache line reads/writebacks, with beat (de)serialisation.
module mem_arbiter #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic                 i_read,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_resp,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_resp,
    output logic [ADDR_W-1:0]    bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);
    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_BITS / 8);

    typedef enum logic [2:0] {ST_IDLE, ST_RD_CMD, ST_RD_DATA, ST_WR, ST_RESP} state_t;
    typedef enum logic {GNT_I, GNT_D} gnt_t;

    state_t               r_state;
    gnt_t                 r_last_grant;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic [LINE_BITS-1:0] r_line;

    logic                 w_i_req;
    logic                 w_d_req;
    logic                 w_pick_d;
    logic                 w_last;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [ADDR_W-1:0]    w_addr_sel;
    logic [LINE_BITS-1:0] w_fill;

    always_comb begin
        w_i_req    = i_read;
        w_d_req    = d_read | d_write;
        // r_last_grant doubles as the owner of the transaction in flight
        w_pick_d   = w_d_req && (!w_i_req || r_last_grant == GNT_I);
        w_addr_sel = w_pick_d ? d_addr : i_addr;
        w_addr_sel[OFF_W-1:0] = '0;
        w_cnt_nxt  = r_beat_cnt + CNT_W'(1);
        w_last     = (r_beat_cnt == CNT_W'(BEATS - 1));
        w_fill     = r_line;
        w_fill[int'(r_beat_cnt)*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GNT_D;
            r_beat_cnt   <= '0;
            r_line       <= '0;
            i_rdata      <= '0;
            i_resp       <= 1'b0;
            d_rdata      <= '0;
            d_resp       <= 1'b0;
            bmem_addr    <= '0;
            bmem_read    <= 1'b0;
            bmem_write   <= 1'b0;
            bmem_wdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_i_req || w_d_req) begin
                        r_last_grant <= w_pick_d ? GNT_D : GNT_I;
                        bmem_addr    <= w_addr_sel;
                        r_beat_cnt   <= '0;
                        if (w_pick_d && d_write) begin
                            r_line     <= d_wdata;
                            bmem_write <= 1'b1;
                            bmem_wdata <= d_wdata[BEAT_BITS-1:0];
                            r_state    <= ST_WR;
                        end else begin
                            bmem_read <= 1'b1;
                            r_state   <= ST_RD_CMD;
                        end
                    end
                end
                ST_RD_CMD: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (bmem_rvalid) begin
                        r_line     <= w_fill;
                        r_beat_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            // Final beat goes straight to the response register
                            bmem_addr <= '0;
                            r_state   <= ST_RESP;
                            if (r_last_grant == GNT_I) begin
                                i_resp  <= 1'b1;
                                i_rdata <= w_fill;
                            end else begin
                                d_resp  <= 1'b1;
                                d_rdata <= w_fill;
                            end
                        end
                    end
                end
                ST_WR: begin
                    if (bmem_ready) begin
                        r_beat_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            bmem_write <= 1'b0;
                            bmem_wdata <= '0;
                            bmem_addr  <= '0;
                            d_resp     <= 1'b1;
                            r_state    <= ST_RESP;
                        end else begin
                            bmem_wdata <= r_line[int'(w_cnt_nxt)*BEAT_BITS +: BEAT_BITS];
                        end
                    end
                end
                ST_RESP: begin
                    i_resp  <= 1'b0;
                    d_resp  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a hand-driven burst memory.
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    mem_arbiter #(.LINE_BITS(256), .BEAT_BITS(64), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [63:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    // Waits for the read command, accepts it, then returns four beats.
    // noisy adds stray rvalid pulses before/at acceptance and gaps between beats.
    task automatic serve_read(input logic [255:0] line, input logic [31:0] exp_addr,
                              input bit noisy, output int unsigned wait_cyc);
        logic [255:0] l;
        l = line;
        wait_cyc = 0;
        while (!bmem_read && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_eq("rd_cmd", 256'(bmem_read), 256'(1));
        check_eq("rd_addr", 256'(bmem_addr), 256'(exp_addr));
        if (noisy) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = 64'hDEAD_0000_0000_0001;
            @(negedge clk);
            bmem_rdata  = 64'hDEAD_0000_0000_0002;
        end
        bmem_ready = 1'b1;
        @(negedge clk);
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        check_eq("rd_cmd_drop", 256'(bmem_read), 256'(0));
        for (int b = 0; b < 4; b++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = l[b*64 +: 64];
            @(negedge clk);
            bmem_rvalid = 1'b0;
            if (noisy && b < 3) begin
                bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                @(negedge clk);
            end
        end
    endtask

    task automatic serve_write(input logic [255:0] line, input logic [31:0] exp_addr,
                               input int stall_beat, input int stall_n);
        logic [255:0] l;
        int unsigned n;
        l = line;
        n = 0;
        while (!bmem_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("wr_start", 256'(bmem_write), 256'(1));
        check_eq("wr_addr", 256'(bmem_addr), 256'(exp_addr));
        for (int b = 0; b < 4; b++) begin
            if (b == stall_beat) begin
                bmem_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check_eq("wr_stall_data", 256'(bmem_wdata), 256'(l[b*64 +: 64]));
                    @(negedge clk);
                end
            end
            bmem_ready = 1'b1;
            check_eq("wr_beat", 256'({bmem_write, bmem_wdata}), 256'({1'b1, l[b*64 +: 64]}));
            check_eq("wr_no_read", 256'(bmem_read), 256'(0));
            @(negedge clk);
        end
        bmem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] ln;
        int unsigned  lat;
        rst_n = 1'b0; i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0;
        d_write = 1'b0; d_wdata = '0; bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ctrl", 256'({i_resp, d_resp, bmem_read, bmem_write}), 256'(0));
        check_eq("rst_bus", 256'({bmem_addr, bmem_wdata}), 256'(0));
        check_eq("rst_irdata", i_rdata, '0);
        check_eq("rst_drdata", d_rdata, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single icache read
        ln = mk(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        i_addr = 32'h0000_1234; i_read = 1'b1;
        serve_read(ln, 32'h0000_1220, 1'b0, lat);
        check_eq("rd_grant_lat", 256'(lat), 256'(1));
        check_eq("t1_resp", 256'({i_resp, d_resp}), 256'(2'b10));
        check_eq("t1_rdata", i_rdata, ln);
        i_read = 1'b0;
        @(negedge clk);
        check_eq("t1_resp_pulse", 256'({i_resp, d_resp}), 256'(0));
        check_eq("t1_rdata_hold", i_rdata, ln);

        // dcache writeback with a 2-cycle stall on beat 1
        ln = mk(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
        d_addr = 32'h0000_0080; d_wdata = ln; d_write = 1'b1;
        serve_write(ln, 32'h0000_0080, 1, 2);
        check_eq("t2_resp", 256'({i_resp, d_resp}), 256'(2'b01));
        check_eq("t2_idle_bus", 256'({bmem_write, bmem_read}), 256'(0));
        d_write = 1'b0;
        @(negedge clk);
        check_eq("t2_resp_pulse", 256'(d_resp), 256'(0));

        // Contention from reset: expect I,D,I,D,I,D
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
        i_read = 1'b1; d_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bit gi;
            gi = (k % 2 == 0);
            ln = mk(64'(k * 16 + 1), 64'(k * 16 + 2), 64'(k * 16 + 3), 64'(k * 16 + 4));
            serve_read(ln, gi ? 32'h0000_0100 : 32'h0000_0200, 1'b0, lat);
            check_eq("arb_resp", 256'({i_resp, d_resp}), gi ? 256'(2'b10) : 256'(2'b01));
            check_eq("arb_rdata", gi ? i_rdata : d_rdata, ln);
            if (k == 4) i_read = 1'b0;
            if (k == 5) d_read = 1'b0;
        end
        @(negedge clk);

        // Stray rvalid in IDLE and in RD_CMD, gaps between beats
        bmem_rvalid = 1'b1; bmem_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        bmem_rvalid = 1'b0;
        ln = mk(64'h0123_4567_89AB_CDEF, 64'h1357_9BDF_0246_8ACE,
                64'hFEDC_BA98_7654_3210, 64'h0F0F_F0F0_5A5A_A5A5);
        i_addr = 32'h0000_401F; i_read = 1'b1;
        serve_read(ln, 32'h0000_4000, 1'b1, lat);
        check_eq("t4_resp", 256'({i_resp, d_resp}), 256'(2'b10));
        check_eq("t4_rdata", i_rdata, ln);
        i_read = 1'b0;
        @(negedge clk);

        // Reset after 2 of 4 beats
        d_addr = 32'h0000_0300; d_read = 1'b1;
        lat = 0;
        while (!bmem_read && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        bmem_ready = 1'b1;
        @(negedge clk);
        bmem_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bmem_rvalid = 1'b1; bmem_rdata = 64'(32'hCAFE_0000 + b);
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        rst_n = 1'b0; d_read = 1'b0;
        #1;
        check_eq("abort_ctrl", 256'({i_resp, d_resp, bmem_read, bmem_write}), 256'(0));
        check_eq("abort_bus", 256'({bmem_addr, bmem_wdata}), 256'(0));
        check_eq("abort_irdata", i_rdata, '0);
        check_eq("abort_drdata", d_rdata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("abort_no_resp", 256'({i_resp, d_resp, bmem_read}), 256'(0));
        end
        ln = mk(64'h5555_0000_0000_0001, 64'h5555_0000_0000_0002,
                64'h5555_0000_0000_0003, 64'h5555_0000_0000_0004);
        d_addr = 32'h0000_0340; d_read = 1'b1;
        serve_read(ln, 32'h0000_0340, 1'b0, lat);
        check_eq("t5_resp", 256'({i_resp, d_resp}), 256'(2'b01));
        check_eq("t5_rdata", d_rdata, ln);
        d_read = 1'b0;
        @(negedge clk);

        // d_read and d_write together behave as a write
        ln = mk(64'h6666_0000_0000_00A0, 64'h6666_0000_0000_00B0,
                64'h6666_0000_0000_00C0, 64'h6666_0000_0000_00D0);
        d_addr = 32'h0000_0040; d_wdata = ln; d_read = 1'b1; d_write = 1'b1;
        serve_write(ln, 32'h0000_0040, -1, 0);
        check_eq("t6_resp", 256'({i_resp, d_resp}), 256'(2'b01));
        check_eq("t6_rdata_hold", d_rdata, mk(64'h5555_0000_0000_0001, 64'h5555_0000_0000_0002,
                                              64'h5555_0000_0000_0003, 64'h5555_0000_0000_0004));
        d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        check_eq("t6_done", 256'({d_resp, bmem_read, bmem_write}), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
